// File: rtl/divider_arbiter.sv
// divider_arbiter
// Round-robin scheduler sharing one restoring divider among N requesters.
// A granted request is loaded into the divider and run to completion. The
// arbiter then waits for the divider to drop Done and returns the result to
// the winner with a one-cycle pulse. Divide-by-zero is answered locally. A
// watchdog turns a divider that never finishes into an error response.
//
// Ports
//   Clock, Reset           : rising-edge clock, synchronous active-high reset
//   req[N]                 : request levels, held until the response pulse
//   opa/opb[N*n]           : dividends / divisors, requester i at [i*n +: n]
//   grant[N]               : one-hot owner while busy, else 0
//   busy                   : arbiter not idle
//   resp_valid[N]          : one-cycle response pulse to the served requester
//   res_q/res_r/res_dz/res_err : result fields, 0 unless resp_valid != 0
//   div_s/div_LA/div_EB/div_DataA/div_DataB : control and data to the divider
//   div_Q/div_R/div_Done   : results and completion from the divider
module divider_arbiter #(
  parameter int N       = 4,
  parameter int n       = 8,
  parameter int TIMEOUT = 20
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [N-1:0]   req,
  input  logic [N*n-1:0] opa,
  input  logic [N*n-1:0] opb,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic [N-1:0]   resp_valid,
  output logic [n-1:0]   res_q,
  output logic [n-1:0]   res_r,
  output logic           res_dz,
  output logic           res_err,
  output logic           div_s,
  output logic           div_LA,
  output logic           div_EB,
  output logic [n-1:0]   div_DataA,
  output logic [n-1:0]   div_DataB,
  input  logic [n-1:0]   div_Q,
  input  logic [n-1:0]   div_R,
  input  logic           div_Done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] g_reg, g_next;
  logic [n-1:0]  dataa_reg, dataa_next;
  logic [n-1:0]  datab_reg, datab_next;
  logic [n-1:0]  q_reg, q_next;
  logic [n-1:0]  r_reg, r_next;
  logic          dz_reg, dz_next;
  logic          err_reg, err_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Round-robin search starting one past the last served requester.
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [n-1:0]  win_a, win_b;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_found && req[(int'(ptr_reg) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr_reg) + k) % N);
      end
    end
  end

  assign win_a = opa[win_idx * n +: n];
  assign win_b = opb[win_idx * n +: n];

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    g_next     = g_reg;
    dataa_next = dataa_reg;
    datab_next = datab_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dz_next    = dz_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (win_found) begin
          g_next   = win_idx;
          err_next = 1'b0;
          if (win_b == '0) begin
            // Answered without the divider; its data inputs keep old values.
            q_next     = '1;
            r_next     = win_a;
            dz_next    = 1'b1;
            state_next = S_RESP;
          end else begin
            dataa_next = win_a;
            datab_next = win_b;
            q_next     = '0;
            r_next     = '0;
            dz_next    = 1'b0;
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cnt_next   = '0;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (cnt_reg != CW'(TIMEOUT)) begin
          cnt_next = cnt_reg + CW'(1);
        end
        // Completion wins over a timeout landing on the same cycle.
        if (div_Done) begin
          q_next     = div_Q;
          r_next     = div_R;
          state_next = S_DRAIN;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          q_next     = '0;
          r_next     = '0;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A hung divider may never drop Done, so an error leaves at once.
        if (err_reg || !div_Done) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        ptr_next   = g_reg;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      ptr_reg   <= IW'(N - 1);
      g_reg     <= '0;
      dataa_reg <= '0;
      datab_reg <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dz_reg    <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      g_reg     <= g_next;
      dataa_reg <= dataa_next;
      datab_reg <= datab_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      dz_reg    <= dz_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  logic in_resp;
  assign busy    = (state_reg != S_IDLE);
  assign in_resp = (state_reg == S_RESP);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_owner
      assign grant[gi]      = busy    && (g_reg == IW'(gi));
      assign resp_valid[gi] = in_resp && (g_reg == IW'(gi));
    end
  endgenerate

  assign res_q   = in_resp ? q_reg : '0;
  assign res_r   = in_resp ? r_reg : '0;
  assign res_dz  = in_resp && dz_reg;
  assign res_err = in_resp && err_reg;

  assign div_s     = (state_reg == S_LOAD) || (state_reg == S_RUN);
  assign div_LA    = (state_reg == S_LOAD);
  assign div_EB    = (state_reg == S_LOAD);
  assign div_DataA = dataa_reg;
  assign div_DataB = datab_reg;

endmodule

// File: tb/tb_divider_arbiter.sv
module tb_divider_arbiter;

  localparam int N       = 4;
  localparam int n       = 8;
  localparam int TIMEOUT = 20;
  localparam int STUB_D  = n + 1;   // divider completion cycles in RUN

  logic           Clock;
  logic           Reset;
  logic [N-1:0]   req;
  logic [N*n-1:0] opa, opb;
  logic [N-1:0]   grant, resp_valid;
  logic           busy, res_dz, res_err;
  logic [n-1:0]   res_q, res_r;
  logic           div_s, div_LA, div_EB, div_Done;
  logic [n-1:0]   div_DataA, div_DataB, div_Q, div_R;

  divider_arbiter #(.N(N), .n(n), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .opa(opa), .opb(opb),
    .grant(grant), .busy(busy), .resp_valid(resp_valid),
    .res_q(res_q), .res_r(res_r), .res_dz(res_dz), .res_err(res_err),
    .div_s(div_s), .div_LA(div_LA), .div_EB(div_EB),
    .div_DataA(div_DataA), .div_DataB(div_DataB),
    .div_Q(div_Q), .div_R(div_R), .div_Done(div_Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- divider stand-in ----------------
  // Done rises in the STUB_D-th RUN cycle and falls as soon as s drops.
  logic [n-1:0] st_a, st_b;
  logic         st_run;
  int           st_cnt;
  logic         hang;

  always @(posedge Clock) begin
    if (Reset) begin
      st_run <= 1'b0; st_cnt <= 0; st_a <= '0; st_b <= '0;
    end else if (div_s && div_LA && div_EB) begin
      st_a <= div_DataA; st_b <= div_DataB; st_run <= 1'b1; st_cnt <= 0;
    end else if (st_run && div_s) begin
      st_cnt <= st_cnt + 1;
    end else begin
      st_run <= 1'b0;
    end
  end

  assign div_Done = st_run && div_s && !div_LA && !hang && (st_cnt >= STUB_D - 1);
  assign div_Q    = (st_b == 0) ? '1 : st_a / st_b;
  assign div_R    = (st_b == 0) ? st_a : st_a % st_b;

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit           rst_seen = 0;
  bit           m_busy = 0;
  int           m_p, m_end, m_w;
  int           m_ptr = N - 1;
  logic [n-1:0] m_q, m_r, m_lasta = '0, m_lastb = '0;
  logic         m_dz, m_err;
  int           served_cnt[N];
  int           s_cnt = 0;

  int           n_log = 0;
  int           log_idx[64], log_q[64], log_r[64], log_dz[64], log_err[64], log_cyc[64];

  always @(negedge Clock) begin
    logic [N-1:0] e_grant, e_resp;
    logic [n-1:0] e_q, e_r;
    logic         e_busy, e_dz, e_err, e_s, e_ld;
    e_grant = '0; e_resp = '0; e_q = '0; e_r = '0;
    e_busy = 1'b0; e_dz = 1'b0; e_err = 1'b0; e_s = 1'b0; e_ld = 1'b0;
    if (m_busy) begin
      e_busy = 1'b1;
      e_grant[m_w] = 1'b1;
      if (m_p == m_end) begin
        e_resp[m_w] = 1'b1;
        e_q = m_q; e_r = m_r; e_dz = m_dz; e_err = m_err;
      end else if (m_p == 1) begin
        e_s = 1'b1; e_ld = 1'b1;
      end else if (m_p <= m_end - 2) begin
        e_s = 1'b1;
      end
    end

    if (rst_seen) begin
      check("grant", grant, e_grant);
      check("busy", busy, e_busy);
      check("resp_valid", resp_valid, e_resp);
      check("res_q", res_q, e_q);
      check("res_r", res_r, e_r);
      check("res_dz", res_dz, e_dz);
      check("res_err", res_err, e_err);
      check("div_s", div_s, e_s);
      check("div_LA", div_LA, e_ld);
      check("div_EB", div_EB, e_ld);
      check("div_DataA", div_DataA, m_lasta);
      check("div_DataB", div_DataB, m_lastb);
      if (div_s) s_cnt++;
      if (resp_valid != 0 && n_log < 64) begin
        for (int i = N - 1; i >= 0; i--) if (resp_valid[i]) log_idx[n_log] = i;
        log_q[n_log] = res_q; log_r[n_log] = res_r;
        log_dz[n_log] = res_dz; log_err[n_log] = res_err; log_cyc[n_log] = cyc;
        $display("txn cycle=%0d requester=%0d q=%0d r=%0d dz=%0d err=%0d",
                 cyc, log_idx[n_log], res_q, res_r, res_dz, res_err);
        n_log++;
      end
    end

    // advance the model to the next cycle
    if (Reset) begin
      rst_seen = 1; m_busy = 0; m_ptr = N - 1; m_lasta = '0; m_lastb = '0;
    end else if (m_busy) begin
      if (m_p == m_end) begin
        m_busy = 0; m_ptr = m_w; served_cnt[m_w]++;
      end else begin
        m_p++;
      end
    end else if (req != 0) begin
      logic [n-1:0] a, b;
      bit found;
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1; m_w = (m_ptr + k) % N;
        end
      end
      a = opa[m_w * n +: n];
      b = opb[m_w * n +: n];
      m_busy = 1; m_p = 1;
      if (b == 0) begin
        m_dz = 1; m_err = 0; m_q = '1; m_r = a; m_end = 1;
      end else begin
        m_dz = 0; m_lasta = a; m_lastb = b;
        if (hang) begin
          m_err = 1; m_q = '0; m_r = '0; m_end = TIMEOUT + 3;
        end else begin
          m_err = 0; m_q = a / b; m_r = a % b; m_end = STUB_D + 3;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int seen_cnt[N];
  int req_cyc[N];

  task automatic step();
    @(posedge Clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (served_cnt[i] != seen_cnt[i]) begin
        req[i] = 1'b0;
        seen_cnt[i] = served_cnt[i];
      end
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    opa[i * n +: n] = n'(a);
    opb[i * n +: n] = n'(b);
    req[i] = 1'b1;
    req_cyc[i] = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((m_busy || req != 0) && k < budget) begin
      step();
      k++;
    end
    check("wait_bound", k < budget, 1);
  endtask

  task automatic check_log(input int at, input int idx, input int q, input int r,
                           input int dz, input int err);
    check("log_idx", log_idx[at], idx);
    check("log_q", log_q[at], q);
    check("log_r", log_r[at], r);
    check("log_dz", log_dz[at], dz);
    check("log_err", log_err[at], err);
  endtask

  int base, s0;
  int exp_q[4] = '{14, 7, 0, 15};
  int exp_r[4] = '{2, 3, 9, 15};

  initial begin
    Reset = 1'b1; req = '0; opa = '0; opb = '0; hang = 1'b0;
    step(); step();
    Reset = 1'b0;
    step(); step();

    // single normal request: 30 / 5
    base = n_log; s0 = s_cnt;
    set_req(0, 30, 5);
    wait_idle(100);
    check("t1_count", n_log - base, 1);
    check_log(base, 0, 6, 0, 0, 0);
    check("t1_latency", log_cyc[base] - req_cyc[0], 3 + STUB_D);
    check("t1_s_cycles", s_cnt - s0, STUB_D + 1);

    // all four at once after reset: order 0,1,2,3
    Reset = 1'b1; step(); Reset = 1'b0; step();
    base = n_log;
    set_req(0, 100, 7); set_req(1, 45, 6); set_req(2, 9, 10); set_req(3, 255, 16);
    wait_idle(300);
    check("t2_count", n_log - base, 4);
    for (int j = 0; j < 4; j++) check_log(base + j, j, exp_q[j], exp_r[j], 0, 0);

    // divide by zero
    step();
    base = n_log;
    set_req(2, 17, 0);
    wait_idle(50);
    check("t3_count", n_log - base, 1);
    check_log(base, 2, 255, 17, 1, 0);
    check("t3_latency", log_cyc[base] - req_cyc[2], 1);

    // round-robin order after serving 1, then wrap after serving 3
    step();
    set_req(1, 20, 4);
    wait_idle(100);
    base = n_log;
    set_req(0, 60, 7); set_req(3, 81, 9);
    wait_idle(200);
    check("t4a_count", n_log - base, 2);
    check_log(base, 3, 9, 0, 0, 0);
    check_log(base + 1, 0, 8, 4, 0, 0);
    set_req(3, 12, 5);
    wait_idle(100);
    base = n_log;
    set_req(3, 13, 2); set_req(0, 14, 3);
    wait_idle(200);
    check("t4b_count", n_log - base, 2);
    check_log(base, 0, 4, 2, 0, 0);
    check_log(base + 1, 3, 6, 1, 0, 0);

    // hung divider -> watchdog error, then normal service
    hang = 1'b1;
    base = n_log;
    set_req(1, 50, 3);
    wait_idle(100);
    check("t5_count", n_log - base, 1);
    check_log(base, 1, 0, 0, 0, 1);
    check("t5_latency", log_cyc[base] - req_cyc[1], 3 + TIMEOUT);
    hang = 1'b0;
    step();
    base = n_log;
    set_req(1, 50, 3);
    wait_idle(100);
    check_log(base, 1, 16, 2, 0, 0);

    // reset in the middle of RUN aborts, then a re-issued request completes
    step();
    base = n_log;
    set_req(0, 200, 9);
    repeat (5) step();
    check("t6_in_run", div_s, 1);
    Reset = 1'b1; req = '0;
    step();
    Reset = 1'b0;
    check("t6_busy_after_reset", busy, 0);
    check("t6_grant_after_reset", grant, 0);
    step(); step();
    check("t6_no_resp", n_log - base, 0);
    set_req(0, 200, 9);
    wait_idle(100);
    check("t6_count", n_log - base, 1);
    check_log(base, 0, 22, 2, 0, 0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin scheduler that shares one `divider` instance (n-bit restoring divider with `s`/`LA`/`EB`/`Done` handshake) among N requesters. It grants one request at a time and sequences the divider's load/start/done/release protocol. It returns quotient and remainder to the winner with a one-cycle response pulse. Divide-by-zero requests are answered locally without touching the divider, and a watchdog reports a divider that never completes.

## Interface
- `N`, 4, number of requesters
- `n`, 8, operand/result width; must match the shared divider's `n`
- `TIMEOUT`, 20, max cycles in RUN before abort (≥ n+2)
- `Clock`  in  1  single clock, all logic on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `req`  in  N  per-requester request level
- `opa`  in  N*n  dividends, requester i at bits [i*n +: n]
- `opb`  in  N*n  divisors, same packing
- `grant`  out  N  one-hot owner, valid LOAD..RESP (and DZ path), else 0
- `busy`  out  1  state ≠ IDLE
- `resp_valid`  out  N  one-cycle pulse to the served requester
- `res_q`, `res_r`  out  n each  quotient / remainder, valid while resp_valid≠0
- `res_dz`  out  1  divide-by-zero flag, valid with resp_valid
- `res_err`  out  1  timeout flag, valid with resp_valid
- `div_s`, `div_LA`, `div_EB`  out  1 each  to divider
- `div_DataA`, `div_DataB`  out  n each  to divider
- `div_Q`, `div_R`  in  n each  from divider
- `div_Done`  in  1  from divider

## Operation
- States: IDLE, LOAD, RUN, DRAIN, RESP.
- **IDLE**: if `req`≠0, pick the winner by round-robin, searching from `ptr+1` upward mod N. Latch index g, `opa[g]`, `opb[g]`.
  - If `opb[g]`==0: go to RESP with q=all ones, r=`opa[g]`, dz=1. The divider is not touched.
  - Otherwise go to LOAD.
- **LOAD** (exactly 1 cycle): `div_LA`=`div_EB`=`div_s`=1; `div_DataA/B` = latched operands. Next state RUN; clear the watchdog counter.
- **RUN**: `div_s`=1, LA=EB=0. The watchdog increments each cycle.
  - On `div_Done`=1: capture `div_Q`/`div_R` and go to DRAIN.
  - If the counter reaches TIMEOUT first: set err=1, q=r=0, go to DRAIN.
- **DRAIN**: `div_s`=0. Wait for `div_Done`=0 (divider back in idle), then go to RESP. Also exit on err after 1 cycle.
- **RESP** (exactly 1 cycle): `resp_valid[g]`=1; `res_*` driven from internal registers; `ptr`←g; next state IDLE.
- Requester rules:
  - Hold `req` and operands stable until its `resp_valid` pulse.
  - Drop `req` in the cycle after the pulse.
  - Operands are sampled only at grant.
- Requests that arrive while busy wait; nothing is lost and there is no queueing beyond the `req` level.
- `div_DataA/B` hold their last values outside LOAD. `div_LA`/`div_EB`/`div_s` are 0 outside LOAD/RUN.
- `res_q`/`res_r`/`res_dz`/`res_err` are 0 whenever `resp_valid`==0.

## Timing
- All outputs are registered-state decodes. Reset value of every output is 0; state=IDLE, `ptr`=N-1 so requester 0 wins first.
- Reset in any state aborts the operation: no `resp_valid`, `grant`=0 on the next cycle. The top level drives the divider's `Resetn` = ~`Reset`, so both blocks restart together.
- Latency for a normal request: grant edge → LOAD 1 cycle → RUN D cycles (D = divider completion, n+1 for n=8) → DRAIN 1 cycle → RESP 1 cycle. That is 3+D cycles from first IDLE cycle with `req` high to `resp_valid`.
- Divide-by-zero latency: 1 cycle (IDLE→RESP).
- Simultaneous requests are resolved in the same IDLE cycle; only the winner gets `grant`.
- Pointer wrap: after serving N-1, the search starts at 0.
- `div_Done` already high on entry to RUN (stale) must not occur, because DRAIN guarantees it is low. If it does occur, it is treated as completion.
- Watchdog counter width is ⌈log2(TIMEOUT+1)⌉; it saturates and never wraps.

## Test plan
- req0, A=30, B=5, real divider → `resp_valid`=0001 after 3+D cycles, q=6, r=0, dz=0, err=0; `div_s` high for exactly D+1 cycles.
- req0..3 asserted together (A=100,B=7 / 45,6 / 9,10 / 255,16) → service order 0,1,2,3; results 14r2, 7r3, 0r9, 15r15; one pulse each; grant one-hot throughout.
- req2 A=17, B=0 → `resp_valid`=0100 one cycle after the request; q=255, r=17, dz=1; `div_s`/`div_LA`/`div_EB` stay 0.
- After serving requester 1, assert req0 and req3 together → 3 served before 0. After serving 3, assert req3 and req0 → 0 served first (wrap).
- Divider stub holding `div_Done`=0 → err=1, q=r=0 after TIMEOUT RUN cycles plus DRAIN; next request is served normally.
- `Reset` pulsed mid-RUN → no `resp_valid`; all outputs 0 next cycle; a re-issued request then completes correctly.
